// File: rtl/inv_bist_ctrl_if.sv
// Port bundle between the test-control logic, the BIST sequencer and the inverter cell under test.
// The slave modport is the sequencer's view; the master modport is the controller plus inverter side.
interface inv_bist_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int ERR_W = 8
);
  // Handshake: start is a one-cycle request and is taken only while busy=0 (IDLE or DONE);
  // once done=1, pass/err_cnt/fail_idx are valid and hold until the next accepted start.
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [IDX_W-1:0] fail_idx;
  logic             drv_x;
  logic             sense_f;
  logic [2:0]       state_dbg;

  modport master (
    output start,
    output sense_f,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  fail_idx,
    input  drv_x,
    input  state_dbg
  );

  modport slave (
    input  start,
    input  sense_f,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output fail_idx,
    output drv_x,
    output state_dbg
  );
endinterface

// File: rtl/inv_bist_ctrl.sv
// BIST sequencer for one CMOS inverter: applies 1,0,1,0... on drv_x and checks sense_f == ~drv_x.
// Optional macro INV_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module inv_bist_ctrl #(
  parameter int NUM_VEC    = 8,
  parameter int SETTLE_CYC = 2,
  parameter int IDX_W      = 4,
  parameter int ERR_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  inv_bist_ctrl_if.slave bif
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drv_x_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [IDX_W-1:0] fail_idx_q;

  logic accept;
  logic mismatch;
  logic last_vec;

  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && bif.start;
  // Case inequality so an undriven (X/Z) switch output is scored as a failure.
  assign mismatch = (bif.sense_f !== ~drv_x_q);
  assign last_vec = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
`ifdef INV_BIST_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
        end
`else
        if (last_vec) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
        end
`endif
      end
      DONE: begin
        if (accept) begin
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result flags settle one cycle after entering DONE, which gives the
  // NUM_VEC*(SETTLE_CYC+2)+1 cycle run length seen from the start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      drv_x_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            drv_x_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_idx_q <= '0;
          end else if (state_q == DONE) begin
            drv_x_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0);
          end
        end
        DRIVE: begin
          drv_x_q <= ~idx_q[0];
          cnt_q   <= CNT_LOAD;
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            // err_q can never return to zero mid-run, so zero marks the first failure.
            if (err_q == '0) begin
              fail_idx_q <= idx_q;
            end
            if (err_q != ERR_MAX) begin
              err_q <= err_q + 1'b1;
            end
          end
          if (!last_vec) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          idx_q <= idx_q;
        end
      endcase
    end
  end

  assign bif.drv_x     = drv_x_q;
  assign bif.busy      = busy_q;
  assign bif.done      = done_q;
  assign bif.pass      = pass_q;
  assign bif.err_cnt   = err_q;
  assign bif.fail_idx  = fail_idx_q;
  assign bif.state_dbg = state_q;

endmodule

// File: tb/tb_inv_bist_ctrl.sv
// Self-checking bench for inv_bist_ctrl: fault-model inverter, expected-result queue, reset and restart cases.
module tb_inv_bist_ctrl;

  localparam int NUM_VEC    = 8;
  localparam int SETTLE_CYC = 2;
  localparam int IDX_W      = 4;
  localparam int ERR_W      = 8;
  localparam int W          = 8 + 1 + IDX_W + ERR_W;

  logic clk;
  logic rst;
  logic [1:0] fault;

  int checks;
  int errors;
  int exp_napp;
  logic [W-1:0] exp_q[$];

  inv_bist_ctrl_if #(.IDX_W(IDX_W), .ERR_W(ERR_W)) bif ();
  inv_bist_ctrl_if #(.IDX_W(IDX_W), .ERR_W(2))     bif2 ();

  inv_bist_ctrl #(
    .NUM_VEC(NUM_VEC), .SETTLE_CYC(SETTLE_CYC), .IDX_W(IDX_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bif(bif)
  );

  inv_bist_ctrl #(
    .NUM_VEC(NUM_VEC), .SETTLE_CYC(SETTLE_CYC), .IDX_W(IDX_W), .ERR_W(2)
  ) dut_sat (
    .clk(clk),
    .rst(rst),
    .bif(bif2)
  );

  // Inverter model: 0 good, 1 stuck buffer, 2 stuck-at-0.
  assign bif.sense_f  = (fault == 2'd0) ? ~bif.drv_x :
                        (fault == 2'd1) ?  bif.drv_x : 1'b0;
  assign bif2.sense_f = bif2.drv_x;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Driver: computes the expected outcome for the fault model, then pulses start.
  task automatic start_run(input logic [1:0] f, input bit push);
    int err;
    int fidx;
    int napp;
    bit d;
    bit s;
    fault = f;
    err = 0;
    fidx = 0;
    napp = 0;
    for (int i = 0; i < NUM_VEC; i++) begin
      d = (i % 2 == 0);
      s = (f == 2'd0) ? !d : (f == 2'd1) ? d : 1'b0;
      napp = i + 1;
      if (s == d) begin
        if (err == 0) fidx = i;
        if (err < 255) err++;
`ifdef INV_BIST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    exp_napp = napp;
    if (push) begin
      exp_q.push_back({8'(napp * (SETTLE_CYC + 2) + 1), (err == 0), IDX_W'(fidx), ERR_W'(err)});
    end
    @(negedge clk);
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
  endtask

  // Follows a run from the accepting edge; optionally re-pulses start while busy.
  task automatic wait_run(input int repulse_c);
    int done_c;
    logic [W-1:0] e;
    done_c = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      bif.start = (c == repulse_c);
      if (c == 2) begin
        chk("busy_mid", bif.busy, 1);
        chk("done_mid", bif.done, 0);
      end
      if ((c % 4 == 2) && (c / 4 < exp_napp)) begin
        chk($sformatf("drv_x_v%0d", c / 4), bif.drv_x, ((c / 4) % 2 == 0) ? 1 : 0);
      end
      if (bif.done) begin
        done_c = c;
        break;
      end
    end
    bif.start = 1'b0;
    if (done_c < 0) begin
      chk("done_timeout", 0, 1);
    end
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("done_cycle", done_c, e[W-1 -: 8]);
      chk("pass", bif.pass, e[IDX_W + ERR_W]);
      chk("fail_idx", bif.fail_idx, e[IDX_W + ERR_W - 1 -: IDX_W]);
      chk("err_cnt", bif.err_cnt, e[ERR_W-1:0]);
      chk("busy_end", bif.busy, 0);
      chk("drv_x_end", bif.drv_x, 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fault = 2'd0;
    bif.start = 1'b0;
    bif2.start = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_pass", bif.pass, 0);
    chk("rst_err", bif.err_cnt, 0);
    chk("rst_fail_idx", bif.fail_idx, 0);
    chk("rst_drv_x", bif.drv_x, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Good inverter, then stuck buffer, then stuck-at-0.
    start_run(2'd0, 1'b1);
    wait_run(0);
    start_run(2'd1, 1'b1);
    wait_run(0);
    start_run(2'd2, 1'b1);
    wait_run(0);

    // Reset pulse during vector 3 aborts the run.
    start_run(2'd2, 1'b0);
    repeat (13) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_busy", bif.busy, 0);
    chk("abort_done", bif.done, 0);
    chk("abort_err", bif.err_cnt, 0);
    chk("abort_fail_idx", bif.fail_idx, 0);
    chk("abort_drv_x", bif.drv_x, 0);
    #19 rst = 1'b1;
    start_run(2'd0, 1'b1);
    wait_run(0);

    // Randomised re-pulse of start during vector 2 must not disturb the run.
    start_run(2'd0, 1'b1);
    wait_run($urandom_range(9, 11));
    start_run(2'd2, 1'b1);
    chk("restart_done_clr", bif.done, 0);
    chk("restart_pass_clr", bif.pass, 0);
    wait_run(0);

    // Narrow error counter saturates at 3 with a stuck buffer.
    @(negedge clk);
    bif2.start = 1'b1;
    @(negedge clk);
    bif2.start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (bif2.done) break;
    end
    chk("sat_done", bif2.done, 1);
`ifdef INV_BIST_STOP_ON_FAIL_EN
    chk("sat_err", bif2.err_cnt, 1);
`else
    chk("sat_err", bif2.err_cnt, 3);
`endif
    chk("sat_pass", bif2.pass, 0);
    chk("sat_fail_idx", bif2.fail_idx, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_bist_ctrl.md
Name: inv_bist_ctrl

Overview:
- Built-in self-test sequencer for the switch-level CMOS inverter cell.
- On a start pulse it drives a fixed alternating vector sequence onto the inverter input and waits a programmable settle time per vector.
- It then samples the inverter output, checks it against the complemented drive and accumulates a saturating error count.
- Sits between the test-control logic and one inverter instance; reports busy/done/pass plus first-failure index.

Parameters:
- NUM_VEC, 8, number of vectors applied per run (>=1).
- SETTLE_CYC, 2, clock cycles between driving a vector and sampling the output (>=1).
- IDX_W, 4, width of the vector index; must satisfy 2**IDX_W >= NUM_VEC.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle run request; honoured only in IDLE or DONE.
- drv_x  output  1  drive to inverter input x.
- sense_f  input  1  inverter output f (synchronous to clk).
- busy  output  1  high while a run is in progress.
- done  output  1  high from end of run until next accepted start.
- pass  output  1  valid when done; 1 if err_cnt == 0.
- err_cnt  output  ERR_W  mismatches seen this run, saturating at all-ones.
- fail_idx  output  IDX_W  index of the first failing vector; 0 if none.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; drv_x=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0.
  - Internal vector index and settle counter are cleared.
- Vector i drives drv_x = ~i[0], so the sequence is 1,0,1,0,...
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE/DONE, start=1:
  - Next cycle: state=DRIVE, busy=1, done=0, pass=0, err_cnt=0, fail_idx=0, idx=0.
- DRIVE: drv_x <= ~idx[0]; settle counter loaded with SETTLE_CYC-1; go to SETTLE.
- SETTLE: decrement the counter each cycle; when it reaches 0, go to SAMPLE. Per-vector time is therefore 1+SETTLE_CYC+1 cycles.
- SAMPLE: mismatch = (sense_f != ~drv_x).
  - On mismatch, err_cnt increments, holding at 2**ERR_W-1 when saturated.
  - On the first mismatch of the run, fail_idx <= idx.
  - If idx==NUM_VEC-1, go to DONE. Otherwise idx++ and go to DRIVE.
- DONE: busy=0, done=1, pass=(err_cnt==0). drv_x returns to 0. Outputs hold until the next accepted start.
- start while busy is ignored, with no restart and no effect on counters.
- Total run length from the start-accepting edge to done=1 is NUM_VEC*(SETTLE_CYC+2)+1 cycles.
- rst asserted mid-run aborts immediately to the reset values; no partial result is retained.
- sense_f is X/Z (undriven switch output): this counts as a mismatch; the compare uses case-inequality semantics.

Optional Feature:
- Macro: INV_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE. err_cnt=1, fail_idx=failing idx, pass=0. Remaining vectors are not applied.
- Undefined: all NUM_VEC vectors are always applied; err_cnt reflects the total mismatches.

Test Plan:
- Good inverter, defaults; pulse start:
  - drv_x sequence is 1,0,1,0,1,0,1,0.
  - done rises 33 cycles after the start edge; pass=1, err_cnt=0, fail_idx=0.
- sense_f forced equal to drv_x (stuck-buffer fault), macro undefined:
  - err_cnt=8, fail_idx=0, pass=0.
- sense_f stuck-at-0:
  - Mismatches occur on vectors 1,3,5,7 (drv_x=0 expects 1).
  - err_cnt=4, fail_idx=1, pass=0. With INV_BIST_STOP_ON_FAIL_EN: err_cnt=1, fail_idx=1, done after vector 1.
- rst pulsed low for 20 ns during vector 3:
  - All outputs go to reset values asynchronously; busy=0, done=0.
  - A new start then runs the full sequence from idx 0.
- start re-pulsed while busy=1 at vector 2:
  - The run continues unchanged; done timing is unchanged.
  - A second start after done clears done and pass, and a fresh run begins.
- ERR_W=2, NUM_VEC=8, sense_f=drv_x:
  - err_cnt saturates at 3 (no wrap to 0); pass=0.
